// File: rtl/blink_led_multi.sv
// blink_led_multi: N_CH independent LED blinkers sharing one millisecond
// prescaler. Each channel runs in toggle mode (square wave, 2*period ms) or
// pulse mode (1 ms high every period ms). New period/mode values are only
// taken at a period boundary, so a running period is never cut short.
//
// Optional feature: define BLINK_LED_SYNC_EN to add the 'sync' input, which
// phase-aligns every channel and the prescaler in a single cycle.
module blink_led_multi #(
  parameter int N_CH        = 4,
  parameter int PERIOD_W    = 16,
  parameter int CLKS_PER_MS = 100000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
`ifdef BLINK_LED_SYNC_EN
  input  logic                     sync,
`endif
  input  logic [N_CH*PERIOD_W-1:0] period,
  input  logic [N_CH-1:0]          mode,
  output logic [N_CH-1:0]          led,
  output logic                     ms_tick
);

  localparam int                 PRESC_W    = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLKS_PER_MS - 1);
  localparam logic [PERIOD_W-1:0] ONE_MS    = PERIOD_W'(1);

  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic                ms_tick_q, ms_tick_d;
  logic [PERIOD_W-1:0] cnt_q [N_CH];
  logic [PERIOD_W-1:0] cnt_d [N_CH];
  logic [PERIOD_W-1:0] sp_q  [N_CH];
  logic [PERIOD_W-1:0] sp_d  [N_CH];
  logic [N_CH-1:0]     sm_q, sm_d;
  logic [N_CH-1:0]     led_q, led_d;
  logic                tick;

  // The millisecond boundary: last prescaler count of an enabled cycle.
  assign tick = en && (presc_q == PRESC_LAST);

  // Next-state for prescaler, tick output and every channel.
  always_comb begin
    // NOTE: every variable gets its hold value first, so no path through
    // the branches below can leave one unassigned and infer a latch.
    presc_d   = presc_q;
    ms_tick_d = tick;
    cnt_d     = cnt_q;
    sp_d      = sp_q;
    sm_d      = sm_q;
    led_d     = led_q;

    if (en) begin
      presc_d = tick ? '0 : presc_q + PRESC_W'(1);
    end

    if (tick) begin
      for (int i = 0; i < N_CH; i++) begin
        if (sp_q[i] == '0) begin
          // Channel off: stay dark and keep sampling the period input.
          led_d[i] = 1'b0;
          cnt_d[i] = '0;
          sp_d[i]  = period[i*PERIOD_W +: PERIOD_W];
          sm_d[i]  = mode[i];
        end else if (cnt_q[i] != sp_q[i] - ONE_MS) begin
          cnt_d[i] = cnt_q[i] + ONE_MS;
          if (sm_q[i]) begin
            led_d[i] = 1'b0;
          end
        end else begin
          // Period boundary: the only point where new settings take effect.
          cnt_d[i] = '0;
          sp_d[i]  = period[i*PERIOD_W +: PERIOD_W];
          sm_d[i]  = mode[i];
          if (mode[i]) begin
            led_d[i] = 1'b1;
          end else if (!sm_q[i]) begin
            led_d[i] = ~led_q[i];
          end
          // Pulse -> toggle switch keeps the current level until next wrap.
        end
      end
    end

`ifdef BLINK_LED_SYNC_EN
    // Sync wins over a coincident tick and works even while disabled.
    if (sync) begin
      presc_d   = '0;
      ms_tick_d = 1'b0;
      led_d     = '0;
      for (int i = 0; i < N_CH; i++) begin
        cnt_d[i] = '0;
        sp_d[i]  = period[i*PERIOD_W +: PERIOD_W];
        sm_d[i]  = mode[i];
      end
    end
`endif
  end

  // State registers with asynchronous active-high clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the per-channel arrays are ordinary flops, not a RAM, so they
      // are cleared element by element in the asynchronous reset.
      presc_q   <= '0;
      ms_tick_q <= 1'b0;
      sm_q      <= '0;
      led_q     <= '0;
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= '0;
        sp_q[i]  <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed above, independent of statement order.
      presc_q   <= presc_d;
      ms_tick_q <= ms_tick_d;
      cnt_q     <= cnt_d;
      sp_q      <= sp_d;
      sm_q      <= sm_d;
      led_q     <= led_d;
    end
  end

  assign led     = led_q;
  assign ms_tick = ms_tick_q;

endmodule

// File: tb/tb_blink_led_multi.sv
// Testbench for blink_led_multi (CLKS_PER_MS=4, N_CH=4, PERIOD_W=8).
// Directed table of known-good LED/tick values, hand-written corner cases
// and a randomized run against a millisecond-timeline reference model.
module tb_blink_led_multi;

  localparam int N_CH        = 4;
  localparam int PERIOD_W    = 8;
  localparam int CLKS_PER_MS = 4;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     en;
  logic                     sync;
  logic [N_CH*PERIOD_W-1:0] period;
  logic [N_CH-1:0]          mode;
  logic [N_CH-1:0]          led;
  logic                     ms_tick;

  blink_led_multi #(
    .N_CH        (N_CH),
    .PERIOD_W    (PERIOD_W),
    .CLKS_PER_MS (CLKS_PER_MS)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
`ifdef BLINK_LED_SYNC_EN
    .sync    (sync),
`endif
    .period  (period),
    .mode    (mode),
    .led     (led),
    .ms_tick (ms_tick)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: a global millisecond counter and, per channel, the
  // millisecond at which the current period began.
  int     m_phase;
  bit     m_tick;
  longint m_ms;
  longint m_start [N_CH];
  int     m_per   [N_CH];
  bit     m_mode  [N_CH];
  bit     m_led   [N_CH];

  function automatic logic [N_CH-1:0] m_led_vec();
    logic [N_CH-1:0] v;
    for (int i = 0; i < N_CH; i++) v[i] = m_led[i];
    return v;
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_tick  = 0;
    m_ms    = 0;
    for (int i = 0; i < N_CH; i++) begin
      m_start[i] = 0;
      m_per[i]   = 0;
      m_mode[i]  = 0;
      m_led[i]   = 0;
    end
  endtask

  task automatic model_edge();
    if (reset) begin
      model_reset();
      return;
    end
`ifdef BLINK_LED_SYNC_EN
    if (sync) begin
      m_phase = 0;
      m_tick  = 0;
      for (int i = 0; i < N_CH; i++) begin
        m_led[i]   = 0;
        m_start[i] = m_ms;
        m_per[i]   = int'(period[i*PERIOD_W +: PERIOD_W]);
        m_mode[i]  = mode[i];
      end
      return;
    end
`endif
    m_tick = 0;
    if (!en) return;
    m_tick  = (m_phase == CLKS_PER_MS - 1);
    m_phase = (m_phase + 1) % CLKS_PER_MS;
    if (!m_tick) return;
    m_ms++;
    for (int i = 0; i < N_CH; i++) begin
      if (m_per[i] == 0) begin
        m_led[i]   = 0;
        m_start[i] = m_ms;
        m_per[i]   = int'(period[i*PERIOD_W +: PERIOD_W]);
        m_mode[i]  = mode[i];
      end else if (m_ms - m_start[i] == longint'(m_per[i])) begin
        m_start[i] = m_ms;
        if (mode[i])      m_led[i] = 1;
        else if (!m_mode[i]) m_led[i] = ~m_led[i];
        m_per[i]  = int'(period[i*PERIOD_W +: PERIOD_W]);
        m_mode[i] = mode[i];
      end else if (m_mode[i]) begin
        m_led[i] = 0;
      end
    end
  endtask

  // One clock: model advances on the edge, outputs compared on the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
    check("model_led", led, m_led_vec());
    check("model_tick", ms_tick, m_tick);
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    repeat (2) step();
    reset = 1'b0;
    cyc   = 0;
  endtask

  function automatic logic [N_CH*PERIOD_W-1:0] pack4(input int p3, input int p2,
                                                     input int p1, input int p0);
    return {PERIOD_W'(p3), PERIOD_W'(p2), PERIOD_W'(p1), PERIOD_W'(p0)};
  endfunction

  typedef struct {
    int              cyc;
    logic [N_CH-1:0] led;
    logic            tick;
  } vec_t;

  vec_t vecs [12];

  initial begin
    // ch0=3 toggle, ch1=5 pulse, ch2=2 toggle, ch3=0 (off)
    vecs[0]  = '{3,  4'b0000, 1'b0};
    vecs[1]  = '{4,  4'b0000, 1'b1};
    vecs[2]  = '{5,  4'b0000, 1'b0};
    vecs[3]  = '{12, 4'b0100, 1'b1};
    vecs[4]  = '{15, 4'b0100, 1'b0};
    vecs[5]  = '{16, 4'b0101, 1'b1};
    vecs[6]  = '{20, 4'b0001, 1'b1};
    vecs[7]  = '{24, 4'b0011, 1'b1};
    vecs[8]  = '{27, 4'b0011, 1'b0};
    vecs[9]  = '{28, 4'b0100, 1'b1};
    vecs[10] = '{40, 4'b0001, 1'b1};
    vecs[11] = '{44, 4'b0111, 1'b1};

    reset  = 1'b1;
    en     = 1'b0;
    sync   = 1'b0;
    period = '0;
    mode   = '0;
    do_reset();
    check("reset_led", led, 4'b0000);
    check("reset_tick", ms_tick, 1'b0);

    // Directed table.
    en     = 1'b1;
    period = pack4(0, 2, 5, 3);
    mode   = 4'b0010;
    for (int k = 0; k < 12; k++) begin
      run_to(vecs[k].cyc);
      check($sformatf("tbl%0d_led", k), led, vecs[k].led);
      check($sformatf("tbl%0d_tick", k), ms_tick, vecs[k].tick);
    end

    // Asynchronous reset between edges while LEDs are lit.
    #2 reset = 1'b1;
    #1;
    check("async_rst_led", led, 4'b0000);
    check("async_rst_tick", ms_tick, 1'b0);
    model_reset();
    repeat (2) step();
    reset = 1'b0;
    cyc   = 0;
    run_to(3);
    check("rst_restart_no_tick", ms_tick, 1'b0);
    run_to(4);
    check("rst_restart_first_tick", ms_tick, 1'b1);
    run_to(12);
    check("rst_restart_ch2", led, 4'b0100);

    // Mid-period change on ch2: 4 ms period completes, then 2 ms periods.
    do_reset();
    period = pack4(0, 4, 0, 0);
    mode   = 4'b0000;
    run_to(10);
    period = pack4(0, 2, 0, 0);
    run_to(19); check("chg_19", led, 4'b0000);
    run_to(20); check("chg_20", led, 4'b0100);
    run_to(27); check("chg_27", led, 4'b0100);
    run_to(28); check("chg_28", led, 4'b0000);
    run_to(36); check("chg_36", led, 4'b0100);

    // Enable low for 10 cycles: everything freezes, timing shifts by 10.
    do_reset();
    period = pack4(0, 0, 0, 3);
    run_to(17);
    check("frz_pre_led", led, 4'b0001);
    en = 1'b0;
    repeat (10) begin
      step();
      check("frz_led", led, 4'b0001);
      check("frz_tick", ms_tick, 1'b0);
    end
    en = 1'b1;
    run_to(29); check("frz_no_tick_29", ms_tick, 1'b0);
    run_to(30); check("frz_tick_30", ms_tick, 1'b1);
    run_to(37); check("frz_led_37", led, 4'b0001);
    run_to(38); check("frz_led_38", led, 4'b0000);

`ifdef BLINK_LED_SYNC_EN
    // Sync coincident with a tick: tick suppressed, channels re-phased.
    do_reset();
    period = pack4(0, 0, 2, 3);
    run_to(11);
    sync = 1'b1;
    run_to(12);
    check("sync_tick", ms_tick, 1'b0);
    check("sync_led", led, 4'b0000);
    sync = 1'b0;
    run_to(16); check("sync_tick_16", ms_tick, 1'b1);
    run_to(20); check("sync_led_20", led, 4'b0010);
    run_to(24); check("sync_led_24", led, 4'b0011);
`endif

    // Randomized run: model compares led and ms_tick every cycle.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 39) == 0) begin
        for (int i = 0; i < N_CH; i++)
          period[i*PERIOD_W +: PERIOD_W] = PERIOD_W'($urandom_range(0, 6));
      end
      if ($urandom_range(0, 29) == 0) mode = N_CH'($urandom);
`ifdef BLINK_LED_SYNC_EN
      sync = ($urandom_range(0, 199) == 0);
`endif
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
